adc_spi_model_mc: RTL and testbench
===================================

Name: adc_spi_model_mc

Overview:
- Parametrised, multi-channel SPI A2D converter behavioural model, the successor to the single-purpose ADC128S model used in the Segway top-level bench.
- Sits between the DUT's A2D SPI master pins and per-channel stimulus buses: load cells, battery, and any future analog inputs.
- Adds configurable channel count and resolution, an auto-scan mode, a one-frame pipelined response, and error and status reporting.

Parameters:
- NUM_CH, 8, number of analog channels (1..8); the channel address is 3 bits.
- RES, 12, converter resolution in bits (8..12).
- AUTO_SCAN, 0: 0 means the channel is taken from the MOSI address field; 1 means the channel auto-increments each frame, wrapping at NUM_CH-1 and ignoring MOSI.
- CH_RST, 0, the channel returned in the first frame after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- SS_n  in  1  SPI slave select, active low.
- SCLK  in  1  SPI clock from the master; idles high.
- MOSI  in  1  SPI data from the master.
- MISO  out  1  SPI data to the master.
- ch_val  in  NUM_CH*RES  packed per-channel sample values; channel k occupies [k*RES +: RES].
- frame_done  out  1  one-clk pulse when a complete 16-bit frame ends.
- frame_err  out  1  one-clk pulse when SS_n rises mid-frame.
- addr_err  out  1  sticky flag: an address >= NUM_CH was received; cleared by reset only.
- last_ch  out  3  channel served in the most recently completed frame.
- frame_cnt  out  16  count of completed frames; wraps 0xFFFF -> 0.

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-low on rst_n. SS_n, SCLK and MOSI pass through a 2-flop synchronizer into clk. Edges are detected on the synchronized signals.
- Reset values: MISO=0, frame_done=0, frame_err=0, addr_err=0, last_ch=0, frame_cnt=0, next channel register=CH_RST, state=IDLE.
- Frame format: exactly 16 SCLK cycles, MSB first.
  - MOSI bits [13:11] carry the channel address; all other MOSI bits are ignored.
  - The MISO word is {4'b0000, sample[RES-1:0], (12-RES) zero bits}, i.e. left-aligned to 12 bits.
- Pipelining: data returned in frame N belongs to the channel addressed in frame N-1, or to CH_RST for the first frame after reset.
- State machine:
  - IDLE: MISO=0. A synchronized SS_n fall latches ch_val of the pending channel into the 16-bit tx shift register, clears the bit counter, and moves to SHIFT.
  - SHIFT: MISO = tx_shift[15] (the first bit is valid before the first SCLK fall). On each SCLK rise, sample MOSI into rx_shift and increment the 5-bit bit counter. On each SCLK fall, shift tx left and fill with 0. When the counter reaches 16, go to DONE.
  - DONE: wait for the SS_n rise. On the rise, in one clk:
    - pulse frame_done;
    - frame_cnt += 1;
    - last_ch = served channel;
    - update the pending channel: in addressed mode from rx_shift[13:11], in auto-scan mode as served+1 mod NUM_CH;
    - return to IDLE.
  - Extra SCLK edges in DONE are ignored and MISO holds 0.
- Abort: SS_n rises in SHIFT with count < 16.
  - frame_err pulses and the state returns to IDLE.
  - The pending channel, last_ch and frame_cnt are unchanged.
- Address out of range (addr >= NUM_CH, addressed mode):
  - addr_err is set;
  - the pending channel is unchanged, so the next frame re-serves the previous channel.
- ch_val is sampled only at the SS_n fall. Changes during a frame do not affect the word in flight.
- SS_n fall and SCLK edge in the same synchronized cycle: the load takes priority and that SCLK edge is ignored. The master is required to hold SS_n setup at least 4 clk.
- Reset mid-frame: immediate return to reset values. The next SS_n fall starts a fresh frame serving CH_RST.
- Minimum SCLK half-period: 4 clk. Faster SCLK is unsupported and not checked.

Test Plan:
- Addressed mode, NUM_CH=8, RES=12: frame 1 sends addr 3, then frame 2 sends addr 5, with ch3=0xABC. Frame 2 MISO = 0x0ABC, last_ch=3 after frame 2, frame_cnt=2.
- RES=10, ch0=0x3FF, CH_RST=0: the first frame returns 0x0FFC (left-aligned), and frame_done pulses exactly 1 clk.
- AUTO_SCAN=1, NUM_CH=3, ch0/1/2 = 0x111/0x222/0x333: four frames return 0x0111, 0x0222, 0x0333, 0x0111, and last_ch wraps 2 -> 0.
- Abort: SS_n rises after 7 SCLKs. frame_err pulses, frame_cnt stays 0, and the next full frame still serves CH_RST.
- NUM_CH=3, send addr 6. addr_err=1, and the next frame serves the previous channel. addr_err stays 1 until rst_n asserts.
- Reset mid-frame after 9 SCLKs: all outputs return to reset values within the same clk, and the next frame returns ch_val[CH_RST].

Source files
------------

// File: rtl/adc_spi_model_mc_if.sv
// adc_spi_model_mc_if: SPI pins between an A2D master and the converter model
interface adc_spi_model_mc_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;
    modport master (output SS_n, SCLK, MOSI, input MISO);
    modport slave (input SS_n, SCLK, MOSI, output MISO);
endinterface

// File: rtl/adc_spi_model_mc.sv
// adc_spi_model_mc: multi-channel SPI A2D model with a one-frame pipelined response
module adc_spi_model_mc #(
    parameter int NUM_CH = 8,
    parameter int RES = 12,
    parameter int AUTO_SCAN = 0,
    parameter int CH_RST = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    adc_spi_model_mc_if.slave       spi,
    input  logic [NUM_CH*RES-1:0]   ch_val,
    output logic                    frame_done,
    output logic                    frame_err,
    output logic                    addr_err,
    output logic [2:0]              last_ch,
    output logic [15:0]             frame_cnt
);
    localparam int PAD = 12 - RES;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t st, nxt;
    // [0],[1] synchronizer stages, [2] previous synchronized value for edge detect
    logic [2:0] ss_q, sclk_q;
    logic [1:0] mosi_q;
    logic [15:0] tx, rx;
    logic [4:0] cnt;
    logic [2:0] pend, serv, addr;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic load, rx_en, tx_en, abort, fin;
    assign ss_fall = ss_q[2] & ~ss_q[1];
    assign ss_rise = ~ss_q[2] & ss_q[1];
    assign sclk_rise = ~sclk_q[2] & sclk_q[1];
    assign sclk_fall = sclk_q[2] & ~sclk_q[1];
    assign addr = rx[13:11];
    assign spi.MISO = (st == SHIFT) && tx[15];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= IDLE;
        else st <= nxt;
    always_comb begin
        load = st == IDLE && ss_fall;
        abort = st == SHIFT && ss_rise;
        fin = st == DONE && ss_rise;
        rx_en = st == SHIFT && !ss_rise && sclk_rise;
        tx_en = st == SHIFT && !ss_rise && sclk_fall;
        nxt = load ? SHIFT : (abort || fin) ? IDLE : (rx_en && cnt == 5'd15) ? DONE : st;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ss_q <= 3'b111;
            sclk_q <= 3'b111;
            mosi_q <= 2'b00;
            tx <= 16'd0;
            rx <= 16'd0;
            cnt <= 5'd0;
            pend <= 3'(CH_RST);
            serv <= 3'(CH_RST);
            frame_done <= 1'b0;
            frame_err <= 1'b0;
            addr_err <= 1'b0;
            last_ch <= 3'd0;
            frame_cnt <= 16'd0;
        end else begin
            ss_q <= {ss_q[1:0], spi.SS_n};
            sclk_q <= {sclk_q[1:0], spi.SCLK};
            mosi_q <= {mosi_q[0], spi.MOSI};
            frame_done <= fin;
            frame_err <= abort;
            if (load) begin
                tx <= 16'(ch_val[pend*RES +: RES]) << PAD;
                cnt <= 5'd0;
                serv <= pend;
            end else if (tx_en)
                tx <= {tx[14:0], 1'b0};
            if (rx_en) begin
                rx <= {rx[14:0], mosi_q[1]};
                cnt <= cnt + 5'd1;
            end
            // an out-of-range address leaves pend alone so the same channel is served again
            if (fin) begin
                frame_cnt <= frame_cnt + 16'd1;
                last_ch <= serv;
                if (AUTO_SCAN != 0) pend <= (serv == 3'(NUM_CH - 1)) ? 3'd0 : serv + 3'd1;
                else if (32'(addr) < NUM_CH) pend <= addr;
                else addr_err <= 1'b1;
            end
        end
endmodule

// File: tb/tb_adc_spi_model_mc.sv
// tb_adc_spi_model_mc: randomized frames on an addressed and an auto-scan instance against a frame-level model
module tb_adc_spi_model_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ss_n = 1'b1, sclk = 1'b1, mosi = 1'b0;
    logic [59:0] cv_a;
    logic [35:0] cv_b;
    logic done_a, err_a, aerr_a, done_b, err_b, aerr_b;
    logic [2:0] last_a, last_b;
    logic [15:0] cnt_a, cnt_b;
    int ch_a[6];
    int ch_b[3];
    int pend_a, pend_b, mlast_a, mlast_b, mcnt_a, mcnt_b, merr_a;
    int passed = 0, total = 0, fails = 0;

    adc_spi_model_mc_if a_if();
    adc_spi_model_mc_if b_if();
    assign a_if.SS_n = ss_n;
    assign a_if.SCLK = sclk;
    assign a_if.MOSI = mosi;
    assign b_if.SS_n = ss_n;
    assign b_if.SCLK = sclk;
    assign b_if.MOSI = mosi;

    adc_spi_model_mc #(.NUM_CH(6), .RES(10), .AUTO_SCAN(0), .CH_RST(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .spi(a_if), .ch_val(cv_a), .frame_done(done_a),
        .frame_err(err_a), .addr_err(aerr_a), .last_ch(last_a), .frame_cnt(cnt_a));
    adc_spi_model_mc #(.NUM_CH(3), .RES(12), .AUTO_SCAN(1), .CH_RST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .spi(b_if), .ch_val(cv_b), .frame_done(done_b),
        .frame_err(err_b), .addr_err(aerr_b), .last_ch(last_b), .frame_cnt(cnt_b));

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend_a = 2; pend_b = 0; mlast_a = 0; mlast_b = 0;
        mcnt_a = 0; mcnt_b = 0; merr_a = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, " cnt_a"}, 32'(cnt_a), 32'(mcnt_a & 16'hFFFF));
        check({tag, " last_a"}, 32'(last_a), 32'(mlast_a));
        check({tag, " aerr_a"}, 32'(aerr_a), 32'(merr_a));
        check({tag, " cnt_b"}, 32'(cnt_b), 32'(mcnt_b & 16'hFFFF));
        check({tag, " last_b"}, 32'(last_b), 32'(mlast_b));
        check({tag, " aerr_b"}, 32'(aerr_b), 32'd0);
    endtask

    // nbits < 16 aborts the frame; keep_ss leaves SS_n low and skips all checks
    task automatic do_frame(input int addr, input int nbits, input bit keep_ss);
        logic [15:0] mw, ra, rb, ea, eb;
        int nd_a, ne_a, nd_b, ne_b;
        for (int k = 0; k < 6; k++) begin
            ch_a[k] = int'($urandom_range(0, 1023));
            cv_a[k*10 +: 10] = 10'(ch_a[k]);
        end
        for (int k = 0; k < 3; k++) begin
            ch_b[k] = int'($urandom_range(0, 4095));
            cv_b[k*12 +: 12] = 12'(ch_b[k]);
        end
        ea = 16'(ch_a[pend_a] * 4);
        eb = 16'(ch_b[pend_b]);
        mw = 16'($urandom);
        mw[13:11] = 3'(addr);
        ra = 16'd0;
        rb = 16'd0;
        ss_n = 1'b0;
        tick(6);
        cv_a = 60'({$urandom(), $urandom()});
        cv_b = 36'({$urandom(), $urandom()});
        tick(2);
        for (int i = 0; i < nbits; i++) begin
            ra[15-i] = a_if.MISO;
            rb[15-i] = b_if.MISO;
            sclk = 1'b0;
            mosi = mw[15-i];
            tick(8);
            sclk = 1'b1;
            tick(8);
        end
        if (!keep_ss) begin
            ss_n = 1'b1;
            nd_a = 0; ne_a = 0; nd_b = 0; ne_b = 0;
            for (int t = 0; t < 12; t++) begin
                tick(1);
                nd_a += int'(done_a); ne_a += int'(err_a);
                nd_b += int'(done_b); ne_b += int'(err_b);
            end
            if (nbits == 16) begin
                check("word_a", 32'(ra), 32'(ea));
                check("word_b", 32'(rb), 32'(eb));
                mlast_a = pend_a; mcnt_a++;
                if (addr < 6) pend_a = addr;
                else merr_a = 1;
                mlast_b = pend_b; mcnt_b++;
                pend_b = (pend_b + 1) % 3;
            end
            check("done_pulses_a", 32'(nd_a), (nbits == 16) ? 32'd1 : 32'd0);
            check("err_pulses_a", 32'(ne_a), (nbits == 16) ? 32'd0 : 32'd1);
            check("done_pulses_b", 32'(nd_b), (nbits == 16) ? 32'd1 : 32'd0);
            check("err_pulses_b", 32'(ne_b), (nbits == 16) ? 32'd0 : 32'd1);
            check_state("frame");
            tick(4);
        end
    endtask

    initial begin
        cv_a = '0;
        cv_b = '0;
        model_reset();
        tick(3);
        check_state("reset");
        check("reset_miso_a", 32'(a_if.MISO), 32'd0);
        check("reset_miso_b", 32'(b_if.MISO), 32'd0);
        check("reset_done", 32'({done_a, done_b, err_a, err_b}), 32'd0);
        rst_n = 1'b1;
        tick(4);
        do_frame(3, 16, 1'b0);
        do_frame(5, 16, 1'b0);
        do_frame(1, 7, 1'b0);
        do_frame(4, 16, 1'b0);
        do_frame(6, 16, 1'b0);
        do_frame(0, 16, 1'b0);
        for (int f = 0; f < 12; f++)
            do_frame(int'($urandom_range(0, 7)),
                     ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16, 1'b0);
        do_frame(2, 9, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("midrst");
        check("midrst_miso_a", 32'(a_if.MISO), 32'd0);
        check("midrst_miso_b", 32'(b_if.MISO), 32'd0);
        ss_n = 1'b1;
        sclk = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        do_frame(1, 16, 1'b0);
        do_frame(7, 16, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
